// File: rtl/bus_master_lsu_pkg.sv
// Shared definitions for the load/store bus initiator: access sizes, FSM states
// and the supported read-latency range.
package bus_master_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Out-of-range latencies saturate so the counter width never has to grow.
    function automatic logic [1:0] clamp_latency(input int lat);
        if (lat < RD_LAT_MIN) begin
            return 2'(RD_LAT_MIN);
        end else if (lat > RD_LAT_MAX) begin
            return 2'(RD_LAT_MAX);
        end
        return 2'(lat);
    endfunction

    function automatic logic misaligned(input size_e size, input logic [1:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/bus_master_lsu_if.sv
// Request/response handshake plus RAM bus signals of the LSU; master is the LSU
// side, slave is the CPU/RAM environment side.
interface bus_master_lsu_if #(
    parameter int ADDR_W = 32
);
    import bus_master_lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    size_e             req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, hrdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, haddr, hwrite, hwdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, hrdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, haddr, hwrite, hwdata
    );

endinterface

// File: rtl/bus_master_lsu_lane_merge.sv
// Combinational byte-lane logic: merges sub-word store data into an old word and
// sign/zero-extends raw load data.
module lsu_lane_merge
    import bus_master_lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic [31:0] raw,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extended
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_B:    merged[{offset, 3'b000} +: 8]      = wdata[7:0];
            SZ_H:    merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    // The responder already shifted the addressed lane down to bit 0.
    always_comb begin
        extended = raw;
        case (size)
            SZ_B:    extended = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_H:    extended = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: extended = raw;
        endcase
    end

endmodule

// File: rtl/bus_master_lsu.sv
// Single-outstanding load/store bus initiator; sub-word stores are performed as
// read-modify-write because the responder only stores full words.
module bus_master_lsu
    import bus_master_lsu_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    bus_master_lsu_if.master    bus
);

    localparam logic [1:0] LAT = clamp_latency(RD_LATENCY);

    state_e            state, state_d;
    logic [1:0]        cnt, cnt_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic              write_q, write_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       merged;
    logic [31:0]       extended;
    logic [ADDR_W-1:0] aligned_addr;

    assign aligned_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};

    lsu_lane_merge u_lane_merge (
        .old_word    (bus.hrdata),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (off_q),
        .raw         (bus.hrdata),
        .is_unsigned (uns_q),
        .merged      (merged),
        .extended    (extended)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            write_q     <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            write_q     <= write_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RD lasts LAT+1 cycles: HADDR is presented, then the registered read data
    // arrives LAT cycles later and is sampled on the last RD edge.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        size_d      = size_q;
        uns_d       = uns_q;
        write_d     = write_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        haddr_d     = haddr_q;
        hwrite_d    = 1'b0;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    write_d = bus.req_write;
                    off_d   = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata;
                    cnt_d   = '0;
                    if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (bus.req_write && (bus.req_size == SZ_W)) begin
                        state_d  = ST_WR;
                        haddr_d  = aligned_addr;
                        hwdata_d = bus.req_wdata;
                        hwrite_d = 1'b1;
                    end else if (bus.req_write) begin
                        state_d = ST_RD;
                        haddr_d = aligned_addr;
                    end else begin
                        state_d = ST_RD;
                        haddr_d = bus.req_addr;
                    end
                end
            end
            ST_RD: begin
                if (cnt == LAT) begin
                    if (write_q) begin
                        state_d  = ST_WR;
                        hwdata_d = merged;
                        hwrite_d = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = extended;
                        rsp_err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt + 2'd1;
                end
            end
            ST_WR: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hwdata    = hwdata_q;

endmodule
